// File: rtl/lbuff_ret_module.sv
// rtl/lbuff_ret_module.sv - load-buffer retire tracker; returns up to 4 in-order committed IDs per cycle
// Optional stall counter output o_lbuff_ret_stall_cnt when LBUFF_RET_STAT_EN is defined.
module lbuff_ret_module #(
   parameter int LBUFF_ENTRIES = 32,
   parameter int LBUFF_ID_W    = 5,
   parameter int RET_W         = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_csr_trap_flush,
   input  logic                  i_exu_ls_flush,
   input  logic                  i_exu_mis_flush,
   input  logic                  i_rob_mis_ld_vld,
   input  logic [LBUFF_ID_W-1:0] i_rob_mis_ld_id,
   input  logic [3:0]            i_lbuff_alloc_vld,
   input  logic [LBUFF_ID_W-1:0] i_lbuff_alloc_id,
   input  logic [3:0]            i_rob_cmt_ld_vld,
   input  logic [LBUFF_ID_W-1:0] i_rob_cmt_ld_id_0,
   input  logic [LBUFF_ID_W-1:0] i_rob_cmt_ld_id_1,
   input  logic [LBUFF_ID_W-1:0] i_rob_cmt_ld_id_2,
   input  logic [LBUFF_ID_W-1:0] i_rob_cmt_ld_id_3,
   output logic [RET_W-1:0]      o_dsp_ldq_ret_vld,
   output logic [LBUFF_ID_W-1:0] o_lbuff_ret_id,
   output logic [LBUFF_ID_W:0]   o_lbuff_occ
`ifdef LBUFF_RET_STAT_EN
   ,
   output logic [31:0]           o_lbuff_ret_stall_cnt
`endif
);

   localparam int SLOTS = 4;
   localparam int RN_W  = $clog2(RET_W + 1);

   typedef logic [LBUFF_ID_W-1:0] id_t;

   logic [LBUFF_ENTRIES-1:0] vld_q, vld_d, cmt_q, cmt_d;
   id_t                      head_q, head_d, tail_q, tail_d;
   logic [RET_W-1:0]         ret_vld_q, ret_vld_d;
   id_t                      ret_id_q;
   logic [LBUFF_ID_W:0]      occ_q, occ_d;

   logic [RN_W-1:0] ret_n;
   logic            ret_stop;
   id_t             cmt_id [SLOTS];
   id_t             alloc_slot [SLOTS];
   id_t             alloc_run;
   id_t             alloc_end;
   id_t             fl_len;
   id_t             fl_off;
   logic            part_flush;

   assign cmt_id[0]  = i_rob_cmt_ld_id_0;
   assign cmt_id[1]  = i_rob_cmt_ld_id_1;
   assign cmt_id[2]  = i_rob_cmt_ld_id_2;
   assign cmt_id[3]  = i_rob_cmt_ld_id_3;
   assign part_flush = (i_exu_ls_flush | i_exu_mis_flush) & i_rob_mis_ld_vld;
   assign fl_len     = tail_q - i_rob_mis_ld_id;

   // Retire window: consecutive valid+committed entries from head, stop at first miss.
   always_comb begin
      ret_n    = '0;
      ret_stop = 1'b0;
      for (int k = 0; k < RET_W; k++) begin
         if (!ret_stop && vld_q[head_q + id_t'(k)] && cmt_q[head_q + id_t'(k)])
            ret_n = ret_n + RN_W'(1);
         else
            ret_stop = 1'b1;
      end
   end

   always_comb begin
      alloc_run = i_lbuff_alloc_id;
      for (int k = 0; k < SLOTS; k++) begin
         alloc_slot[k] = alloc_run;
         alloc_run     = alloc_run + id_t'(i_lbuff_alloc_vld[k]);
      end
      alloc_end = alloc_run;
   end

   always_comb begin
      vld_d  = vld_q;
      cmt_d  = cmt_q;
      head_d = head_q + id_t'(ret_n);
      tail_d = tail_q;
      fl_off = '0;
      occ_d  = '0;
      for (int k = 0; k < RET_W; k++)
         ret_vld_d[k] = (RN_W'(k) < ret_n);

      for (int p = 0; p < SLOTS; p++)
         if (i_rob_cmt_ld_vld[p]) cmt_d[cmt_id[p]] = 1'b1;

      for (int k = 0; k < RET_W; k++) begin
         if (ret_vld_d[k]) begin
            vld_d[head_q + id_t'(k)] = 1'b0;
            cmt_d[head_q + id_t'(k)] = 1'b0;
         end
      end

      // Flushed entries are always younger than anything committing or retiring this cycle.
      if (part_flush) begin
         for (int i = 0; i < LBUFF_ENTRIES; i++) begin
            fl_off = id_t'(i) - i_rob_mis_ld_id;
            if (fl_off < fl_len) begin
               vld_d[i] = 1'b0;
               cmt_d[i] = 1'b0;
            end
         end
         tail_d = i_rob_mis_ld_id;
      end else begin
         for (int k = 0; k < SLOTS; k++) begin
            if (i_lbuff_alloc_vld[k]) begin
               vld_d[alloc_slot[k]] = 1'b1;
               cmt_d[alloc_slot[k]] = 1'b0;
            end
         end
         tail_d = alloc_end;
      end

      for (int i = 0; i < LBUFF_ENTRIES; i++)
         occ_d = occ_d + (LBUFF_ID_W+1)'(vld_d[i]);
   end

   always_ff @(posedge clk) begin
      if (rst || i_csr_trap_flush) begin
         vld_q     <= '0;
         cmt_q     <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         ret_vld_q <= '0;
         ret_id_q  <= '0;
         occ_q     <= '0;
      end else begin
         vld_q     <= vld_d;
         cmt_q     <= cmt_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         ret_vld_q <= ret_vld_d;
         ret_id_q  <= head_q;
         occ_q     <= occ_d;
      end
   end

   assign o_dsp_ldq_ret_vld = ret_vld_q;
   assign o_lbuff_ret_id    = ret_id_q;
   assign o_lbuff_occ       = occ_q;

`ifdef LBUFF_RET_STAT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt_q <= '0;
      else if (vld_q[head_q] && !cmt_q[head_q] && (stall_cnt_q != '1))
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign o_lbuff_ret_stall_cnt = stall_cnt_q;
`endif

   // Dispatch protocol checks: allocation must continue at the tail into free entries,
   // and commits may only target live entries.
   always @(posedge clk) begin
      if (!rst && !i_csr_trap_flush) begin
         for (int p = 0; p < SLOTS; p++)
            if (i_rob_cmt_ld_vld[p]) assert (vld_q[cmt_id[p]]);
         if (!part_flush && (|i_lbuff_alloc_vld)) begin
            assert (i_lbuff_alloc_id == tail_q);
            for (int k = 0; k < SLOTS; k++)
               if (i_lbuff_alloc_vld[k]) assert (!vld_q[alloc_slot[k]]);
         end
      end
   end

endmodule

// File: tb/tb_lbuff_ret_module.sv
// tb/tb_lbuff_ret_module.sv - directed plus randomized bench against a queue-based model
module tb_lbuff_ret_module;

   logic       clk = 1'b0;
   logic       rst, trap, ls_fl, mis_fl, mis_vld;
   logic [4:0] mis_id, a_id;
   logic [3:0] a_vld, c_vld;
   logic [4:0] c_id [4];
   logic [3:0] ret_vld;
   logic [4:0] ret_id;
   logic [5:0] occ;

   int ncmp = 0;
   int nerr = 0;

   // Model: queue of committed flags for live entries, oldest first, plus head ID.
   bit         q[$];
   int         hd = 0;
   logic [3:0] exp_ret;
   logic [4:0] exp_id;
   logic [5:0] exp_occ;

   always #5 clk = ~clk;

   lbuff_ret_module dut (
      .clk               (clk),
      .rst               (rst),
      .i_csr_trap_flush  (trap),
      .i_exu_ls_flush    (ls_fl),
      .i_exu_mis_flush   (mis_fl),
      .i_rob_mis_ld_vld  (mis_vld),
      .i_rob_mis_ld_id   (mis_id),
      .i_lbuff_alloc_vld (a_vld),
      .i_lbuff_alloc_id  (a_id),
      .i_rob_cmt_ld_vld  (c_vld),
      .i_rob_cmt_ld_id_0 (c_id[0]),
      .i_rob_cmt_ld_id_1 (c_id[1]),
      .i_rob_cmt_ld_id_2 (c_id[2]),
      .i_rob_cmt_ld_id_3 (c_id[3]),
      .o_dsp_ldq_ret_vld (ret_vld),
      .o_lbuff_ret_id    (ret_id),
      .o_lbuff_occ       (occ)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] tail5();
      return 5'((hd + q.size()) % 32);
   endfunction

   function automatic int ready_run();
      int n = 0;
      while (n < 4 && n < q.size() && q[n]) n++;
      return n;
   endfunction

   task automatic model_step();
      int n, o, off;
      if (rst || trap) begin
         q.delete();
         hd      = 0;
         exp_ret = '0;
         exp_id  = '0;
      end else begin
         n       = ready_run();
         exp_ret = 4'((1 << n) - 1);
         exp_id  = 5'(hd);
         for (int p = 0; p < 4; p++) begin
            if (c_vld[p]) begin
               off = (int'(c_id[p]) - hd + 32) % 32;
               q[off] = 1'b1;
            end
         end
         if ((ls_fl || mis_fl) && mis_vld) begin
            o = (int'(mis_id) - hd + 32) % 32;
            while (q.size() > o) void'(q.pop_back());
         end else begin
            for (int k = 0; k < 4; k++)
               if (a_vld[k]) q.push_back(1'b0);
         end
         repeat (n) void'(q.pop_front());
         hd = (hd + n) % 32;
      end
      exp_occ = 6'(q.size());
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check("ret_vld", {28'd0, ret_vld}, {28'd0, exp_ret});
      if (exp_ret != 4'd0) check("ret_id", {27'd0, ret_id}, {27'd0, exp_id});
      check("occ", {26'd0, occ}, {26'd0, exp_occ});
   endtask

   task automatic idle();
      rst = 1'b0; trap = 1'b0; ls_fl = 1'b0; mis_fl = 1'b0; mis_vld = 1'b0;
      mis_id = '0; a_vld = '0; a_id = tail5(); c_vld = '0;
      for (int p = 0; p < 4; p++) c_id[p] = '0;
   endtask

   task automatic alloc(input int k);
      a_vld = 4'((1 << k) - 1);
      a_id  = tail5();
   endtask

   task automatic commit(input int p, input int id);
      c_vld[p] = 1'b1;
      c_id[p]  = 5'(id % 32);
   endtask

   initial begin
      int live, n, lim, o, lo, span;
      logic [3:0] m;

      idle();
      rst = 1'b1;
      cyc();
      cyc();
      check("rst_ret_id", {27'd0, ret_id}, 32'd0);

      // Basic in-order return with a hole at ID 2
      idle(); alloc(4); cyc();
      idle(); commit(0, 0); commit(1, 1); commit(2, 3); cyc();
      idle(); cyc();
      check("t2_ret_a", {28'd0, ret_vld}, 32'h3);
      check("t2_id_a", {27'd0, ret_id}, 32'd0);
      idle(); commit(0, 2); cyc();
      idle(); cyc();
      check("t2_ret_b", {28'd0, ret_vld}, 32'h3);
      check("t2_id_b", {27'd0, ret_id}, 32'd2);
      check("t2_occ", {26'd0, occ}, 32'd0);

      // Walk head to 30, then return across the wrap
      repeat (6) begin idle(); alloc(4); cyc(); end
      idle(); alloc(2); cyc();
      for (int i = 4; i < 30; i += 4) begin
         idle();
         for (int p = 0; p < 4; p++) if (i + p < 30) commit(p, i + p);
         cyc();
      end
      repeat (3) begin idle(); cyc(); end
      idle(); alloc(4); cyc();
      idle(); commit(0, 30); commit(1, 31); commit(2, 0); commit(3, 1); cyc();
      idle(); cyc();
      check("t3_ret", {28'd0, ret_vld}, 32'hf);
      check("t3_id", {27'd0, ret_id}, 32'd30);
      idle(); cyc();
      check("t3_head", {27'd0, ret_id}, 32'd2);

      // Full buffer
      repeat (8) begin idle(); alloc(4); cyc(); end
      check("t4_occ", {26'd0, occ}, 32'd32);
      idle(); cyc();
      check("t4_ret0", {28'd0, ret_vld}, 32'h0);
      idle(); commit(0, 2); cyc();
      idle(); cyc();
      check("t4_ret1", {28'd0, ret_vld}, 32'h1);
      for (int i = 3; i < 34; i += 4) begin
         idle();
         for (int p = 0; p < 4; p++) if (i + p < 34) commit(p, i + p);
         cyc();
      end
      repeat (3) begin idle(); cyc(); end

      // Partial flush: head 2, tail 10, flush from 6 with a dropped same-cycle alloc
      idle(); alloc(4); cyc();
      idle(); alloc(4); cyc();
      idle(); mis_fl = 1'b1; mis_vld = 1'b1; mis_id = 5'd6; alloc(2); cyc();
      check("t5_occ", {26'd0, occ}, 32'd4);
      idle(); alloc(4); cyc();
      check("t5_occ2", {26'd0, occ}, 32'd8);
      idle(); for (int p = 0; p < 4; p++) commit(p, 2 + p); cyc();
      idle(); for (int p = 0; p < 4; p++) commit(p, 6 + p); cyc();
      repeat (3) begin idle(); cyc(); end

      // Trap flush with concurrent commits and allocs
      idle(); alloc(4); cyc();
      idle(); commit(0, hd); commit(1, hd + 1); cyc();
      idle(); trap = 1'b1; alloc(4); commit(0, hd); cyc();
      check("t6_ret", {28'd0, ret_vld}, 32'h0);
      check("t6_occ", {26'd0, occ}, 32'd0);
      idle(); alloc(4); cyc();
      idle(); for (int p = 0; p < 4; p++) commit(p, p); cyc();
      idle(); cyc();
      check("t6_id", {27'd0, ret_id}, 32'd0);

      // Randomized traffic, with a mid-traffic reset
      for (int it = 0; it < 600; it++) begin
         idle();
         live = q.size();
         n    = ready_run();
         m    = 4'($urandom);
         if ($countones(m) > 32 - live) m = '0;
         a_vld = m;
         lim   = live;
         if ($urandom_range(0, 15) == 0 && live > 0) begin
            lo      = (n > 0) ? n : ((live == 32) ? 1 : 0);
            o       = $urandom_range(lo, live);
            mis_vld = 1'b1;
            mis_id  = 5'((hd + o) % 32);
            if ($urandom_range(0, 1) == 1) mis_fl = 1'b1; else ls_fl = 1'b1;
            lim = o;
         end else if ($urandom_range(0, 15) == 0) begin
            mis_fl = 1'b1;
            mis_id = 5'($urandom);
         end
         span = (lim > 8) ? 8 : lim;
         for (int p = 0; p < 4; p++)
            if (span > 0 && $urandom_range(0, 1) == 1) commit(p, hd + $urandom_range(0, span - 1));
         if ($urandom_range(0, 63) == 0) trap = 1'b1;
         if (it == 300) begin
            rst = 1'b1;
            cyc();
            cyc();
            check("t1_ret_id", {27'd0, ret_id}, 32'd0);
         end else begin
            cyc();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
